// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, and a held
// output byte that only changes on the cycle valid pulses.
module uart_rx_byte #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_sh;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_ferr;
  logic             w_half;
  logic             w_last;

  assign w_half    = (r_cnt == CNT_HALF);
  assign w_last    = (r_cnt == CNT_LAST);
  assign byte_out  = r_byte;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_sh      <= '0;
      r_byte    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_half) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_sh  <= {r_rx_s, r_sh[7:1]};
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
        S_STOP: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_byte  <= r_sh;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomised frames against a frame-level reference model that
// tracks the last good byte and the expected strobe times.
module tb_uart_rx_byte;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_out;
  logic       valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         vt[$];
  logic [7:0] vd[$];
  int         ft[$];
  logic [7:0] prev_b = 8'h00;
  int         both_hi = 0;
  int         bad_change = 0;
  logic [7:0] model_byte = 8'h00;

  uart_rx_byte #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_out  (byte_out),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vt.push_back(cyc);
      vd.push_back(byte_out);
    end
    if (frame_err) ft.push_back(cyc);
    if (valid && frame_err) both_hi <= both_hi + 1;
    if (rst_n && !valid && byte_out !== prev_b) bad_change <= bad_change + 1;
    prev_b <= byte_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vt.delete();
    vd.delete();
    ft.delete();
  endtask

  // Caller is at a negedge; returns the cycle number of the first edge that samples the start bit.
  task automatic send(input logic [7:0] d, input logic stop, output int e0);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  function automatic logic in_win(input int t, input int e0);
    return (t >= e0 + 2 + CPB/2 + 9*CPB - 1) && (t <= e0 + 2 + CPB/2 + 9*CPB + 1);
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] d, input logic stop, input int e0);
    if (stop) begin
      model_byte = d;
      chk({tag, "_vcnt"}, vt.size(), 1);
      chk({tag, "_fcnt"}, ft.size(), 0);
      chk({tag, "_vlat"}, (vt.size() > 0) ? in_win(vt[0], e0) : 1'b0, 1);
      chk({tag, "_vbyte"}, (vd.size() > 0) ? vd[0] : 8'hxx, d);
    end else begin
      chk({tag, "_vcnt"}, vt.size(), 0);
      chk({tag, "_fcnt"}, ft.size(), 1);
      chk({tag, "_flat"}, (ft.size() > 0) ? in_win(ft[0], e0) : 1'b0, 1);
    end
    chk({tag, "_hold"}, byte_out, model_byte);
  endtask

  initial begin
    int e0, e1;
    logic [7:0] d;
    logic stop;

    // Reset with line idle
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", byte_out, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);

    // Single good byte
    clr();
    send(8'hA5, 1'b1, e0);
    check_frame("a5", 8'hA5, 1'b1, e0);
    repeat (5) @(negedge clk);

    // Short glitch must be rejected
    clr();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_v", vt.size(), 0);
    chk("glitch_f", ft.size(), 0);
    chk("glitch_byte", byte_out, 8'hA5);

    // Framing error with line held low, then recovery
    clr();
    send(8'h3C, 1'b0, e0);
    repeat (50) @(negedge clk);
    check_frame("ferr", 8'h3C, 1'b0, e0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    clr();
    send(8'h5A, 1'b1, e0);
    check_frame("5a", 8'h5A, 1'b1, e0);
    repeat (3) @(negedge clk);

    // Back-to-back frames with a single stop bit
    clr();
    send(8'h12, 1'b1, e0);
    send(8'h34, 1'b1, e1);
    model_byte = 8'h34;
    chk("b2b_vcnt", vt.size(), 2);
    chk("b2b_gap", (vt.size() > 1) ? vt[1] - vt[0] : 0, 100);
    chk("b2b_lat", (vt.size() > 0) ? in_win(vt[0], e0) : 1'b0, 1);
    chk("b2b_first", (vd.size() > 0) ? vd[0] : 8'hxx, 8'h12);
    chk("b2b_second", (vd.size() > 1) ? vd[1] : 8'hxx, 8'h34);
    chk("b2b_hold", byte_out, 8'h34);
    repeat (3) @(negedge clk);

    // Reset during data bit 4 of an 0xFF frame
    clr();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4*CPB + 5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4*CPB + 20) @(negedge clk);
    model_byte = 8'h00;
    chk("midrst_byte", byte_out, 8'h00);
    chk("midrst_v", vt.size(), 0);
    chk("midrst_f", ft.size(), 0);
    clr();
    send(8'h7E, 1'b1, e0);
    check_frame("7e", 8'h7E, 1'b1, e0);

    // Randomised frames, occasional bad stop bit, random idle gaps
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 12)) @(negedge clk);
      clr();
      send(d, stop, e0);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
      end
      check_frame($sformatf("rnd%0d", n), d, stop, e0);
    end

    repeat (5) @(negedge clk);
    chk("never_both", both_hi, 0);
    chk("byte_stable", bad_change, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Receives 8N1 serial bytes on a single RX pin and holds the last correctly framed byte on a stable 8-bit output. It sits directly upstream of the two-digit hex seven-segment driver and feeds its `number` input, so the display always shows the most recent good byte. It also provides one-cycle `valid` and `frame_err` strobes for any other consumer.

## Interface
- `CLK_HZ`, default 12_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- Derived, not overridable:
  - `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division. Must be ≥ 4; violations are a elaboration-time error.
  - `HALF = CLKS_PER_BIT / 2`.

Ports:
- `clk`, input, 1: single system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: serial line. It is asynchronous to `clk` and idles high.
- `byte_out`, output, 8: last correctly framed byte. It is held until the next good byte arrives.
- `valid`, output, 1: one-cycle pulse, asserted in the same cycle `byte_out` updates.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** `rx` passes through two flops to form `rx_s`. Reset value of `rx_s` and its first stage is 1. No other logic uses raw `rx`.
- **Counters:**
  - `cnt` is `$clog2(CLKS_PER_BIT)` bits wide.
  - `bit_idx` is 3 bits.
  - Shift register `sh` is 8 bits.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
- **IDLE:** when `rx_s == 0`, go to START with `cnt <= 0`.
- **START:** `cnt` increments each cycle. At `cnt == HALF-1`:
  - If `rx_s == 0`: go to DATA with `cnt <= 0` and `bit_idx <= 0`.
  - Otherwise the start was false (a glitch): return to IDLE.
- **DATA:** at `cnt == CLKS_PER_BIT-1`:
  - `sh <= {rx_s, sh[7:1]}` (LSB first) and `cnt <= 0`.
  - If `bit_idx == 7`, go to STOP; otherwise increment `bit_idx`.
- **STOP:** at `cnt == CLKS_PER_BIT-1`:
  - If `rx_s == 1`: `byte_out <= sh`, `valid <= 1`, go to IDLE.
  - Otherwise: `frame_err <= 1`, `byte_out` unchanged, go to BREAK.
- **BREAK:** wait for `rx_s == 1`, then go to IDLE. A line held low produces exactly one `frame_err` and no further strobes until it returns high.
- **Strobes:** `valid` and `frame_err` are registered and are high for exactly one cycle. They are never high together.
- **Reset values:** `byte_out = 8'h00` (display shows "00"), `valid = 0`, `frame_err = 0`, `sh = 0`, `cnt = 0`, `bit_idx = 0`.
- **Reset mid-frame:** the partial byte is discarded and the FSM returns to IDLE. The bit after release begins a fresh search for a start bit.
- **Back-to-back frames:** a start bit immediately following a single stop bit must be caught. STOP→IDLE happens at mid-stop-bit, which leaves half a bit period of margin.

## Timing
- **Sample points:**
  - Start bit is checked `HALF` cycles after the FSM enters START.
  - Each data bit and the stop bit are sampled at `CLKS_PER_BIT` intervals after that point, i.e. near mid-bit.
- **Latency:** let `rx` be first sampled low at clk edge E0. Then:
  - `rx_s` goes low at E0+1.
  - START is entered at E0+2.
  - `valid` (or `frame_err`) asserts at E0 + 2 + HALF + 9·CLKS_PER_BIT, ±1 cycle.
- **Data path:** `byte_out` changes only on the edge that raises `valid`. It is constant at all other times, so the downstream display never shows a partial byte.
- **Baud tolerance:** with mid-bit sampling, the combined TX/RX clock error must be ≤ ±4% over the 10-bit frame.
- **Handshake:** none. The consumer has no backpressure, and a new good byte overwrites `byte_out` unconditionally.

## Test plan
All tests use `CLK_HZ=1_000_000` and `BAUD=100_000` (`CLKS_PER_BIT=10`, `HALF=5`).
- **Reset:** assert `rst_n=0` with `rx=1`, release → `byte_out=8'h00`, `valid=0`, `frame_err=0`, FSM in IDLE.
- **Single byte:** drive frame 0xA5 (0, 1,0,1,0,0,1,0,1, 1), with `rx` first low at E0 → `valid` is high for exactly one cycle at E0+97 (±1), `byte_out=8'hA5` from that edge onward, no `frame_err`.
- **Glitch:** `rx` low for 3 cycles then high → no `valid`, no `frame_err`, FSM back in IDLE within HALF+3 cycles, `byte_out` unchanged.
- **Framing error:** after 0xA5 is received, send 0x3C with stop bit low and hold `rx` low for 50 more cycles → exactly one `frame_err` pulse, `byte_out` stays 8'hA5. After `rx` returns high, frame 0x5A → `valid`, `byte_out=8'h5A`.
- **Back-to-back:** send 0x12 and 0x34 with a single stop bit and no idle gap → two `valid` pulses 100 cycles apart, `byte_out` 8'h12 then 8'h34.
- **Reset mid-frame:**
  - Start frame 0xFF and pulse `rst_n` low during data bit 4 → `byte_out=8'h00`, no strobes.
  - Then send a full 0x7E frame → `byte_out=8'h7E`.
